// File: rtl/tv80_bus_bridge.sv
// Bridges the TV80 CPU bus strobes onto a single-outstanding request/ack fabric.
// Inserts CPU wait states while the fabric works and times out a missing ack.
module tv80_bus_bridge #(
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] ERR_DATA = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  input  logic [7:0]  int_vec,
  output logic        req,
  output logic        req_we,
  output logic        req_io,
  output logic [15:0] req_addr,
  output logic [7:0]  req_wdata,
  input  logic        ack,
  input  logic [7:0]  rdata,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t     state, state_d;
  logic [7:0] data_q;
  logic [7:0] timer;
  logic [7:0] cpu_di_c;
  logic       wait_c;
  logic       start, inta, tmo_hit, strobes_idle;

  // Refresh (mreq_n low with no rd/wr) must never become a fabric cycle.
  assign start = (m1_n  && (!mreq_n || !iorq_n) && (!rd_n || !wr_n)) ||
                 (!m1_n && !mreq_n && !rd_n);
  assign inta         = !m1_n && !iorq_n;
  assign tmo_hit      = (state == REQ) && (timer == TMAX);
  assign strobes_idle = rd_n && wr_n && mreq_n && iorq_n;

  always_comb begin
    state_d  = state;
    cpu_di_c = data_q;
    wait_c   = 1'b1;
    case (state)
      IDLE: begin
        if (inta) begin
          cpu_di_c = int_vec;
          state_d  = HOLD;
        end else if (start) begin
          wait_c  = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          if (!req_we) cpu_di_c = rdata;
          state_d = HOLD;
        end else if (tmo_hit) begin
          cpu_di_c = ERR_DATA;
          state_d  = HOLD;
        end else begin
          wait_c = 1'b0;
        end
      end
      HOLD: begin
        if (strobes_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The CPU sees a quiet bus while reset is held, whatever the strobes do.
  assign cpu_di = reset_n ? cpu_di_c : 8'h00;
  assign wait_n = reset_n ? wait_c   : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req       <= 1'b0;
      req_we    <= 1'b0;
      req_io    <= 1'b0;
      req_addr  <= 16'h0000;
      req_wdata <= 8'h00;
      data_q    <= 8'h00;
      timer     <= 8'h00;
      err       <= 1'b0;
    end else begin
      state <= state_d;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (inta) begin
            data_q <= int_vec;
          end else if (start) begin
            req_addr  <= A;
            req_we    <= !wr_n;
            req_io    <= !iorq_n;
            req_wdata <= cpu_dout;
            req       <= 1'b1;
            timer     <= 8'h00;
          end
        end
        REQ: begin
          if (ack) begin
            req <= 1'b0;
            if (!req_we) data_q <= rdata;
          end else if (tmo_hit) begin
            req    <= 1'b0;
            err    <= 1'b1;
            data_q <= ERR_DATA;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Directed bench for tv80_bus_bridge with a short timeout so the error path is reachable.
module tb_tv80_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_di;
  logic        wait_n;
  logic [7:0]  int_vec;
  logic        req, req_we, req_io;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  tv80_bus_bridge #(.TIMEOUT(4), .ERR_DATA(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .A(A), .cpu_dout(cpu_dout), .cpu_di(cpu_di), .wait_n(wait_n), .int_vec(int_vec),
    .req(req), .req_we(req_we), .req_io(req_io), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus_idle();
    A = 16'h0; cpu_dout = 8'h0; int_vec = 8'hAA; ack = 1'b0; rdata = 8'h0;
    step();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", req); end
    n_checks++; if (req_addr !== 16'h0000 || req_wdata !== 8'h00 || req_we !== 1'b0 || req_io !== 1'b0) begin
      n_fail++; $display("FAIL reset_latches got addr=%h wd=%h we=%b io=%b want 0", req_addr, req_wdata, req_we, req_io); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    m1_n = 1'b0; iorq_n = 1'b0;
    #1;
    n_checks++; if (cpu_di !== 8'h00 || wait_n !== 1'b1) begin
      n_fail++; $display("FAIL reset_cpu got di=%h wait_n=%b want 00/1", cpu_di, wait_n); end
    bus_idle();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_mem_read();
    A = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    n_checks++; if (wait_n !== 1'b0 || req !== 1'b0) begin
      n_fail++; $display("FAIL rd_start got wait_n=%b req=%b want 0/0", wait_n, req); end
    step();
    n_checks++; if (req !== 1'b1 || req_addr !== 16'h1234 || req_we !== 1'b0 || req_io !== 1'b0 || wait_n !== 1'b0) begin
      n_fail++; $display("FAIL rd_req1 got req=%b addr=%h we=%b io=%b wait_n=%b want 1/1234/0/0/0", req, req_addr, req_we, req_io, wait_n); end
    step();
    n_checks++; if (req !== 1'b1 || wait_n !== 1'b0) begin
      n_fail++; $display("FAIL rd_req2 got req=%b wait_n=%b want 1/0", req, wait_n); end
    step();
    ack = 1'b1; rdata = 8'h5A;
    #1;
    n_checks++; if (req !== 1'b1 || wait_n !== 1'b1 || cpu_di !== 8'h5A) begin
      n_fail++; $display("FAIL rd_ack got req=%b wait_n=%b di=%h want 1/1/5a", req, wait_n, cpu_di); end
    step();
    ack = 1'b0; rdata = 8'h00;
    #1;
    n_checks++; if (req !== 1'b0 || cpu_di !== 8'h5A || wait_n !== 1'b1) begin
      n_fail++; $display("FAIL rd_hold got req=%b di=%h wait_n=%b want 0/5a/1", req, cpu_di, wait_n); end
    step();
    n_checks++; if (req !== 1'b0 || cpu_di !== 8'h5A) begin
      n_fail++; $display("FAIL rd_no_reissue got req=%b di=%h want 0/5a", req, cpu_di); end
    bus_idle();
    step();
    n_checks++; if (cpu_di !== 8'h5A) begin n_fail++; $display("FAIL rd_idle_di got %h want 5a", cpu_di); end
  endtask

  task automatic test_io_write();
    A = 16'h00FE; cpu_dout = 8'hC3; iorq_n = 1'b0; wr_n = 1'b0;
    #1;
    n_checks++; if (wait_n !== 1'b0) begin n_fail++; $display("FAIL wr_start wait_n got %b want 0", wait_n); end
    step();
    n_checks++; if (req !== 1'b1 || req_io !== 1'b1 || req_we !== 1'b1 || req_wdata !== 8'hC3 || req_addr !== 16'h00FE) begin
      n_fail++; $display("FAIL wr_req got req=%b io=%b we=%b wd=%h addr=%h want 1/1/1/c3/00fe", req, req_io, req_we, req_wdata, req_addr); end
    ack = 1'b1; rdata = 8'h77;
    #1;
    n_checks++; if (wait_n !== 1'b1 || cpu_di !== 8'h5A) begin
      n_fail++; $display("FAIL wr_ack got wait_n=%b di=%h want 1/5a", wait_n, cpu_di); end
    step();
    ack = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL wr_req_drop got %b want 0", req); end
    bus_idle();
    step();
    A = 16'h0042; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    n_checks++; if (wait_n !== 1'b0) begin n_fail++; $display("FAIL wr_back_idle wait_n got %b want 0", wait_n); end
    step();
    ack = 1'b1; rdata = 8'h42;
    step();
    ack = 1'b0;
    bus_idle();
    step();
  endtask

  task automatic test_inta();
    int_vec = 8'hFF; m1_n = 1'b0; iorq_n = 1'b0;
    #1;
    n_checks++; if (cpu_di !== 8'hFF || wait_n !== 1'b1 || req !== 1'b0) begin
      n_fail++; $display("FAIL inta_cycle got di=%h wait_n=%b req=%b want ff/1/0", cpu_di, wait_n, req); end
    step();
    int_vec = 8'h00;
    #1;
    n_checks++; if (cpu_di !== 8'hFF || wait_n !== 1'b1 || req !== 1'b0) begin
      n_fail++; $display("FAIL inta_hold got di=%h wait_n=%b req=%b want ff/1/0", cpu_di, wait_n, req); end
    step();
    n_checks++; if (cpu_di !== 8'hFF || req !== 1'b0) begin
      n_fail++; $display("FAIL inta_hold2 got di=%h req=%b want ff/0", cpu_di, req); end
    bus_idle();
    step();
    n_checks++; if (cpu_di !== 8'hFF || req !== 1'b0) begin
      n_fail++; $display("FAIL inta_release got di=%h req=%b want ff/0", cpu_di, req); end
  endtask

  task automatic test_timeout();
    A = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0;
    step();
    n_checks++; if (req !== 1'b1 || wait_n !== 1'b0) begin
      n_fail++; $display("FAIL to_c1 got req=%b wait_n=%b want 1/0", req, wait_n); end
    step();
    step();
    n_checks++; if (req !== 1'b1 || wait_n !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL to_c3 got req=%b wait_n=%b err=%b want 1/0/0", req, wait_n, err); end
    step();
    n_checks++; if (wait_n !== 1'b1 || cpu_di !== 8'hFF || err !== 1'b0) begin
      n_fail++; $display("FAIL to_c4 got wait_n=%b di=%h err=%b want 1/ff/0", wait_n, cpu_di, err); end
    step();
    n_checks++; if (err !== 1'b1 || req !== 1'b0 || cpu_di !== 8'hFF || wait_n !== 1'b1) begin
      n_fail++; $display("FAIL to_err got err=%b req=%b di=%h wait_n=%b want 1/0/ff/1", err, req, cpu_di, wait_n); end
    step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got %b want 0", err); end
    step();
    ack = 1'b1; rdata = 8'h11;
    #1;
    n_checks++; if (cpu_di !== 8'hFF || req !== 1'b0) begin
      n_fail++; $display("FAIL to_stray_ack got di=%h req=%b want ff/0", cpu_di, req); end
    step();
    ack = 1'b0;
    #1;
    n_checks++; if (cpu_di !== 8'hFF || req !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL to_after_stray got di=%h req=%b err=%b want ff/0/0", cpu_di, req, err); end
    bus_idle();
    step();
  endtask

  task automatic test_ack_at_timeout();
    A = 16'h3000; mreq_n = 1'b0; rd_n = 1'b0;
    step();
    step();
    step();
    step();
    ack = 1'b1; rdata = 8'h3C;
    #1;
    n_checks++; if (cpu_di !== 8'h3C || req !== 1'b1) begin
      n_fail++; $display("FAIL ackto_data got di=%h req=%b want 3c/1", cpu_di, req); end
    step();
    ack = 1'b0;
    #1;
    n_checks++; if (err !== 1'b0 || cpu_di !== 8'h3C || req !== 1'b0) begin
      n_fail++; $display("FAIL ackto_noerr got err=%b di=%h req=%b want 0/3c/0", err, cpu_di, req); end
    bus_idle();
    step();
  endtask

  task automatic test_refresh_reset();
    mreq_n = 1'b0;
    #1;
    n_checks++; if (wait_n !== 1'b1) begin n_fail++; $display("FAIL refresh_wait got %b want 1", wait_n); end
    step();
    step();
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL refresh_req got %b want 0", req); end
    bus_idle();
    step();
    A = 16'h4444; mreq_n = 1'b0; rd_n = 1'b0;
    step();
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got req=%b want 1", req); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0 || cpu_di !== 8'h00 || wait_n !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid got req=%b di=%h wait_n=%b want 0/00/1", req, cpu_di, wait_n); end
    bus_idle();
    step();
    reset_n = 1'b1;
    step();
    ack = 1'b1; rdata = 8'h99;
    #1;
    n_checks++; if (cpu_di !== 8'h00 || wait_n !== 1'b1) begin
      n_fail++; $display("FAIL rst_ack_comb got di=%h wait_n=%b want 00/1", cpu_di, wait_n); end
    step();
    ack = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0 || err !== 1'b0 || cpu_di !== 8'h00) begin
      n_fail++; $display("FAIL rst_ack_ignored got req=%b err=%b di=%h want 0/0/00", req, err, cpu_di); end
    step();
  endtask

  task automatic test_back_to_back();
    A = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0;
    step();
    n_checks++; if (req !== 1'b1 || req_addr !== 16'h0100) begin
      n_fail++; $display("FAIL b2b_req1 got req=%b addr=%h want 1/0100", req, req_addr); end
    ack = 1'b1; rdata = 8'h11;
    #1;
    n_checks++; if (cpu_di !== 8'h11) begin n_fail++; $display("FAIL b2b_data1 got %h want 11", cpu_di); end
    step();
    ack = 1'b0;
    bus_idle();
    step();
    n_checks++; if (req !== 1'b0 || cpu_di !== 8'h11) begin
      n_fail++; $display("FAIL b2b_gap got req=%b di=%h want 0/11", req, cpu_di); end
    step();
    A = 16'h0200; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    n_checks++; if (wait_n !== 1'b0) begin n_fail++; $display("FAIL b2b_start2 wait_n got %b want 0", wait_n); end
    step();
    n_checks++; if (req !== 1'b1 || req_addr !== 16'h0200 || req_we !== 1'b0) begin
      n_fail++; $display("FAIL b2b_req2 got req=%b addr=%h we=%b want 1/0200/0", req, req_addr, req_we); end
    ack = 1'b1; rdata = 8'h22;
    #1;
    n_checks++; if (cpu_di !== 8'h22) begin n_fail++; $display("FAIL b2b_data2 got %h want 22", cpu_di); end
    step();
    ack = 1'b0;
    #1;
    n_checks++; if (req !== 1'b0 || cpu_di !== 8'h22) begin
      n_fail++; $display("FAIL b2b_end got req=%b di=%h want 0/22", req, cpu_di); end
    bus_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_mem_read();
    test_io_write();
    test_inta();
    test_timeout();
    test_ack_at_timeout();
    test_refresh_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
